// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider.
package clk_div_pkg;

    localparam int unsigned DIV_W_DEFAULT = 8;
    localparam int unsigned MIN_DIV       = 2;

    // High-phase length: ceil(n/2), so odd ratios get the extra cycle high.
    function automatic logic [31:0] half_period(input logic [31:0] n);
        return (n >> 1) + 32'(n[0]);
    endfunction

endpackage

// File: rtl/clk_div_cfg_reg.sv
// Divide-ratio load validation, pending register and boundary apply strobe.
module clk_div_cfg_reg
    import clk_div_pkg::*;
#(
    parameter int unsigned DIV_W = DIV_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIV_W-1:0] div_val,
    input  logic             div_load,
    input  logic             boundary,
    output logic [DIV_W-1:0] pend_val,
    output logic             pend_vld,
    output logic             div_err,
    output logic             apply_c
);

    logic load_ok;
    logic load_bad;

    assign load_ok  = div_load && (div_val >= DIV_W'(MIN_DIV));
    assign load_bad = div_load && (div_val <  DIV_W'(MIN_DIV));
    assign apply_c  = boundary && pend_vld;

    // A load on the apply edge wins, so it survives until the next boundary.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_val <= '0;
            pend_vld <= 1'b0;
            div_err  <= 1'b0;
        end else begin
            div_err <= load_bad;
            if (load_ok) begin
                pend_val <= div_val;
                pend_vld <= 1'b1;
            end else if (apply_c) begin
                pend_vld <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with boundary-only ratio changes
// and glitch-free start/stop.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int unsigned DIV_W     = DIV_W_DEFAULT,
    parameter int unsigned RESET_DIV = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [DIV_W-1:0] div_val,
    input  logic             div_load,
    output logic             clk_div,
    output logic             tick,
    output logic [DIV_W-1:0] cur_div,
    output logic             div_pending,
    output logic             div_err,
    output logic             running
);

    localparam logic [DIV_W-1:0] N_RST   = DIV_W'(RESET_DIV);
    localparam logic [DIV_W-1:0] CNT_RST = DIV_W'(RESET_DIV - 1);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] half;
    logic [DIV_W-1:0] cnt_inc;
    logic [DIV_W-1:0] n_next;
    logic [DIV_W-1:0] pend_val;
    logic             pend_vld;
    logic             boundary;
    logic             apply_c;

    assign boundary = (cnt == cur_div - DIV_W'(1));
    assign half     = DIV_W'(half_period(32'(cur_div)));
    assign cnt_inc  = cnt + DIV_W'(1);
    assign n_next   = apply_c ? pend_val : cur_div;

    assign div_pending = pend_vld;

    clk_div_cfg_reg #(
        .DIV_W (DIV_W)
    ) u_cfg (
        .clk      (clk),
        .reset    (reset),
        .div_val  (div_val),
        .div_load (div_load),
        .boundary (boundary),
        .pend_val (pend_val),
        .pend_vld (pend_vld),
        .div_err  (div_err),
        .apply_c  (apply_c)
    );

    // Idle parks the counter at N-1 so the first enabled edge is a boundary.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= CNT_RST;
            cur_div <= N_RST;
            clk_div <= 1'b0;
            tick    <= 1'b0;
            running <= 1'b0;
        end else if (boundary) begin
            cur_div <= n_next;
            if (en) begin
                cnt     <= '0;
                clk_div <= 1'b1;
                tick    <= 1'b1;
                running <= 1'b1;
            end else begin
                cnt     <= n_next - DIV_W'(1);
                clk_div <= 1'b0;
                tick    <= 1'b0;
                running <= 1'b0;
            end
        end else begin
            cnt     <= cnt_inc;
            clk_div <= (cnt_inc < half);
            tick    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed self-checking bench for clk_div_prog with hand-computed waveforms.
module tb_clk_div_prog;

    localparam int unsigned DIV_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic [DIV_W-1:0] div_val;
    logic             div_load;
    logic             clk_div;
    logic             tick;
    logic [DIV_W-1:0] cur_div;
    logic             div_pending;
    logic             div_err;
    logic             running;

    int n_cmp = 0;
    int n_err = 0;

    clk_div_prog #(
        .DIV_W     (DIV_W),
        .RESET_DIV (10)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .div_val     (div_val),
        .div_load    (div_load),
        .clk_div     (clk_div),
        .tick        (tick),
        .cur_div     (cur_div),
        .div_pending (div_pending),
        .div_err     (div_err),
        .running     (running)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [DIV_W-1:0] v);
        div_val  = v;
        div_load = 1'b1;
        step();
        div_load = 1'b0;
    endtask

    // Walks counts start..n-1 of a period, checking level and strobe each cycle.
    task automatic check_period(input string tag, input int unsigned n, input int unsigned start);
        int unsigned h;
        h = (n + 1) / 2;
        for (int unsigned i = start; i < n; i++) begin
            check_eq($sformatf("%s clk_div c%0d", tag, i), 32'(clk_div), 32'(i < h));
            check_eq($sformatf("%s tick c%0d", tag, i), 32'(tick), 32'(i == 0));
            step();
        end
    endtask

    initial begin
        reset    = 1'b1;
        en       = 1'b1;
        div_load = 1'b0;
        div_val  = '0;
        repeat (2) step();
        check_eq("rst clk_div", 32'(clk_div), 32'd0);
        check_eq("rst tick", 32'(tick), 32'd0);
        check_eq("rst cur_div", 32'(cur_div), 32'd10);
        check_eq("rst pending", 32'(div_pending), 32'd0);
        check_eq("rst running", 32'(running), 32'd0);
        check_eq("rst div_err", 32'(div_err), 32'd0);

        reset = 1'b0;
        step();
        check_eq("start running", 32'(running), 32'd1);
        check_eq("start cur_div", 32'(cur_div), 32'd10);
        check_period("p10a", 10, 0);
        check_period("p10b", 10, 0);

        // Illegal ratios 1 then 0
        div_val  = 8'd1;
        div_load = 1'b1;
        step();
        check_eq("err1 div_err", 32'(div_err), 32'd1);
        check_eq("err1 pending", 32'(div_pending), 32'd0);
        div_val = 8'd0;
        step();
        check_eq("err0 div_err", 32'(div_err), 32'd1);
        div_load = 1'b0;
        step();
        check_eq("err done div_err", 32'(div_err), 32'd0);
        check_eq("err pending", 32'(div_pending), 32'd0);
        check_eq("err cur_div", 32'(cur_div), 32'd10);
        check_period("err", 10, 3);

        // Load 7 mid-period
        load(8'd7);
        check_eq("ld7 pending", 32'(div_pending), 32'd1);
        check_eq("ld7 cur_div old", 32'(cur_div), 32'd10);
        check_period("pre7", 10, 1);
        check_eq("ld7 cur_div", 32'(cur_div), 32'd7);
        check_eq("ld7 pending clr", 32'(div_pending), 32'd0);
        check_period("p7", 7, 0);

        // Back-to-back loads: last one wins
        load(8'd4);
        load(8'd6);
        check_eq("ld6 pending", 32'(div_pending), 32'd1);
        check_eq("ld6 cur_div old", 32'(cur_div), 32'd7);
        check_period("pre6", 7, 2);
        check_eq("ld6 cur_div", 32'(cur_div), 32'd6);
        check_period("p6", 6, 0);

        // Back to 10, then stop at count 2
        load(8'd10);
        check_period("pre10", 6, 1);
        check_eq("ld10 cur_div", 32'(cur_div), 32'd10);
        step();
        step();
        en = 1'b0;
        check_period("stop", 10, 2);
        check_eq("idle clk_div", 32'(clk_div), 32'd0);
        check_eq("idle tick", 32'(tick), 32'd0);
        check_eq("idle running", 32'(running), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            check_eq($sformatf("idle%0d clk_div", k), 32'(clk_div), 32'd0);
            check_eq($sformatf("idle%0d running", k), 32'(running), 32'd0);
        end
        en = 1'b1;
        step();
        check_eq("restart running", 32'(running), 32'd1);
        check_period("restart", 10, 0);

        // Reset mid-period with a load pending
        load(8'd5);
        step();
        step();
        check_eq("prerst pending", 32'(div_pending), 32'd1);
        check_eq("prerst clk_div", 32'(clk_div), 32'd1);
        reset = 1'b1;
        #1;
        check_eq("arst clk_div", 32'(clk_div), 32'd0);
        check_eq("arst tick", 32'(tick), 32'd0);
        check_eq("arst running", 32'(running), 32'd0);
        check_eq("arst pending", 32'(div_pending), 32'd0);
        check_eq("arst cur_div", 32'(cur_div), 32'd10);
        step();
        reset = 1'b0;
        step();
        check_period("post-rst", 10, 0);
        check_eq("post-rst cur_div", 32'(cur_div), 32'd10);
        check_eq("post-rst pending", 32'(div_pending), 32'd0);
        check_period("post-rst2", 10, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/clk_div_prog.md
# clk_div_prog

Runtime-programmable integer clock divider. It generates a divided clock-level signal `clk_div` and a one-cycle `tick` strobe from `clk`. The divide ratio is set at run time and changes only at period boundaries, so no runt or stretched phases ever appear. Start and stop are also glitch-free. It serves as the general-purpose divider for peripheral timing, replacing fixed-ratio dividers.

## Interface
- `DIV_W`, 8: width of the divide ratio; max ratio is 2^DIV_W − 1.
- `RESET_DIV`, 10: ratio in effect after reset; legal range is 2 .. 2^DIV_W − 1.

- `clk`  in  1  input clock.
- `reset`  in  1  asynchronous, active-high reset.
- `en`  in  1  run request; sampled only at period boundaries.
- `div_val`  in  DIV_W  requested ratio N (output period = N `clk` cycles).
- `div_load`  in  1  one-cycle strobe; captures `div_val`.
- `clk_div`  out  1  divided clock, registered.
- `tick`  out  1  one-cycle pulse coincident with each `clk_div` rising edge.
- `cur_div`  out  DIV_W  ratio currently in effect.
- `div_pending`  out  1  a loaded ratio is waiting for the next boundary.
- `div_err`  out  1  one-cycle pulse: rejected load (`div_val` < 2).
- `running`  out  1  divider is producing periods.

## Operation
- State: `cnt` (DIV_W), `N` (`cur_div`), `pend_val`, `pend_vld`, `running`.
- Definitions:
  - H = ceil(N/2).
  - `clk_div` is high for counts 0..H−1 and low for counts H..N−1.
  - Even N gives 50% duty; odd N gives one extra high cycle.
- Boundary: any edge where `cnt` == N−1. On a boundary edge, in this order:
  - If `pend_vld` is set: N ← `pend_val`; `pend_vld` ← 0. H is recomputed from the new N.
  - If `en` = 1: `cnt` ← 0; `clk_div` ← 1; `tick` ← 1; `running` ← 1.
  - If `en` = 0: `cnt` holds at N−1 (using the new N); `clk_div` ← 0; `running` ← 0 (idle).
- Non-boundary edge: `cnt` ← `cnt` + 1; `clk_div` ← (`cnt` + 1 < H); `tick` ← 0.
- Stopping:
  - Deasserting `en` mid-period never truncates the period. The current period completes, then the output stays low.
  - Idle re-start: the first edge with `en` = 1 is a boundary, so `clk_div` and `tick` rise 1 cycle later.
- Load handshake:
  - `div_load` with `div_val` ≥ 2: `pend_val` ← `div_val`; `pend_vld` ← 1. Last load wins; it overwrites any pending value.
  - `div_load` with `div_val` < 2: `div_err` pulses for 1 cycle; pending state and N are unchanged.
- A load on a boundary edge is not applied at that edge. It applies at the next boundary; when idle, that is the following cycle.
- Arithmetic:
  - `cnt` compares are unsigned at DIV_W.
  - H = (N >> 1) + N[0], computed at DIV_W.

## Timing
- Reset values (async):
  - `cnt` = RESET_DIV − 1; N = RESET_DIV.
  - `clk_div` = 0; `tick` = 0; `div_err` = 0; `div_pending` = 0; `running` = 0.
- Reset mid-period: all outputs take their reset values immediately. Any pending load is discarded.
- Latency:
  - `en` rises while idle: `clk_div` and `tick` are 1 after the next edge.
  - `div_load`: `div_pending` = 1 after the same edge.
  - New N: takes effect on the first `clk_div` rising edge after the current period ends.
  - `div_err`: asserts the edge after the load.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `clk_div_pkg`: `MIN_DIV` = 2, default `DIV_W`, and a half-period function for H.
- Sub-module `clk_div_cfg_reg`: load validation, pending register, `div_err` generation, and the apply strobe at the boundary.
- Top-level: counter, boundary detection, output registers, and run/idle control.

## Test plan
- Reset with `en` = 1, defaults:
  - `clk_div` rises 1 cycle after release.
  - High 5 / low 5 cycles; `tick` every 10 cycles; `cur_div` = 10.
- Load 7 while running:
  - `div_pending` = 1 until the boundary.
  - The current 10-cycle period completes.
  - Then high 4 / low 3; `cur_div` = 7; `div_pending` = 0.
- Load 1, then load 0:
  - `div_err` pulses 1 cycle each.
  - `cur_div` stays 10; `div_pending` stays 0.
- Back-to-back loads of 4 then 6 within one period: only 6 is applied at the boundary; the period becomes 3 high / 3 low.
- Drop `en` at count 2 of a N = 10 period:
  - The period completes (count 9), then `clk_div` stays 0 and `running` = 0.
  - Re-assert `en`: `clk_div` and `tick` rise next cycle.
- Assert `reset` at count 3 with a load pending:
  - Outputs go to reset values immediately; the pending load is lost.
  - After release, the ratio is 10.
